// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - function codes and output-stage states for the shared-ALU scheduler
package alu_sched_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_FUNC5 = 3'd5
    } alu_func_e;

    localparam int FUNC_ILLEGAL_MIN = 6;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick: first asserted request at or above ptr, wrapping
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                grant_any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin time-multiplexing of one combinational ALU with a registered response
// Optional grant locking for back-to-back ops is built when ALU_SCHED_LOCK_EN is defined.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 3,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*FUNC_WIDTH-1:0]    req_func,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_c,
    input  logic [NUM_REQ-1:0]               req_lock,
    output logic [FUNC_WIDTH-1:0]            alu_func,
    output logic [DATA_WIDTH-1:0]            alu_in1,
    output logic [DATA_WIDTH-1:0]            alu_in2,
    output logic [DATA_WIDTH-1:0]            alu_in3,
    input  logic [DATA_WIDTH-1:0]            alu_out,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [ID_WIDTH-1:0]              resp_id,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic                             resp_err
);

    out_state_e              state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]     resp_id_q, resp_id_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                    resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0]      arb_req;
    logic [NUM_REQ-1:0]      grant;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic                    grant_any;
    logic                    can_issue;
    logic                    issue;
    logic                    illegal;
    logic [FUNC_WIDTH-1:0]   sel_func;
    logic [DATA_WIDTH-1:0]   sel_a, sel_b, sel_c;

`ifdef ALU_SCHED_LOCK_EN
    logic [ID_WIDTH-1:0]     owner_q, owner_d;
    logic                    owner_valid_q, owner_valid_d;

    // A live owner masks everyone else out of arbitration.
    always_comb begin
        arb_req = req_valid;
        if (owner_valid_q && req_valid[owner_q]) begin
            arb_req = NUM_REQ'(1) << owner_q;
        end
    end

    always_comb begin
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        if (can_issue && owner_valid_q && !req_valid[owner_q]) begin
            owner_valid_d = 1'b0;
        end
        if (issue) begin
            owner_d       = grant_idx;
            owner_valid_d = req_lock[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
        end
    end
`else
    logic lock_unused;
    assign lock_unused = ^req_lock;
    assign arb_req     = req_valid;
`endif

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req       (arb_req),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // rst gates issue so nothing is accepted while reset is held.
    always_comb begin
        can_issue = (state_q == OUT_EMPTY) || resp_ready;
        issue     = can_issue && grant_any && !rst;
        req_ready = issue ? grant : '0;
        sel_func  = req_func[int'(grant_idx)*FUNC_WIDTH +: FUNC_WIDTH];
        sel_a     = req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_b     = req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_c     = req_c[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        illegal   = sel_func >= FUNC_WIDTH'(FUNC_ILLEGAL_MIN);
    end

    always_comb begin
        alu_func = '0;
        alu_in1  = '0;
        alu_in2  = '0;
        alu_in3  = '0;
        if (issue && !illegal) begin
            alu_func = sel_func;
            alu_in1  = sel_a;
            alu_in2  = sel_b;
            alu_in3  = sel_c;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        if (issue) begin
            state_d     = OUT_FULL;
            resp_id_d   = grant_idx;
            resp_data_d = illegal ? '0 : alu_out;
            resp_err_d  = illegal;
            rr_ptr_d    = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end else if (state_q == OUT_FULL && resp_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OUT_EMPTY;
            rr_ptr_q    <= '0;
            resp_id_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign resp_valid = (state_q == OUT_FULL);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Time-multiplexes one shared combinational ALU (function codes 0–5, three 32-bit operands, one 32-bit result) among NUM_REQ requesters inside a tile. Round-robin arbitration, valid/ready handshake per requester, one registered response stage. It drives the ALU's function select and operands each cycle and captures the ALU result with the issuing requester's ID.

## Interface
- NUM_REQ, 4, number of requesters (2–8)
- DATA_WIDTH, 32, operand/result width
- FUNC_WIDTH, 3, ALU function code width
- ID_WIDTH, $clog2(NUM_REQ), requester ID width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept
- req_func  in  NUM_REQ*FUNC_WIDTH  function code, requester i at slice i
- req_a / req_b / req_c  in  NUM_REQ*DATA_WIDTH each  operands 1/2/3, requester i at slice i
- req_lock  in  NUM_REQ  hold grant for back-to-back ops (only with ALU_SCHED_LOCK_EN)
- alu_func  out  FUNC_WIDTH  to ALU function select
- alu_in1 / alu_in2 / alu_in3  out  DATA_WIDTH each  to ALU operands
- alu_out  in  DATA_WIDTH  ALU result (combinational from alu_* outputs)
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  ID_WIDTH  index of issuing requester
- resp_data  out  DATA_WIDTH  registered ALU result
- resp_err  out  1  illegal function code (6 or 7)

## Operation
- Output stage FSM: EMPTY, FULL. Reset -> EMPTY.
- can_issue = EMPTY or (FULL and resp_ready).
- Grant: first i with req_valid[i], searching from rr_ptr upward, wrapping modulo NUM_REQ. Combinational; req_ready[i] = grant[i] and can_issue. Exactly one or zero ready bits high.
- Issue (valid&ready on i): alu_func/alu_in* = requester i's slices; capture alu_out, resp_id=i, resp_err=0 into output stage; rr_ptr <= (i+1) mod NUM_REQ.
- Illegal func (6,7): still accepted; alu_func driven 0, alu_in* driven 0; captured resp_data=0, resp_err=1.
- No issue: alu_func=0, alu_in*=0; rr_ptr unchanged.
- Transitions: EMPTY+issue -> FULL; FULL+resp_ready+issue -> FULL (overwrite with new op); FULL+resp_ready+no issue -> EMPTY; FULL+!resp_ready -> FULL, outputs held stable.
- Requester valid must not depend on ready; ready depends on all req_valid.
- rr_ptr never advances on a stall or on an unaccepted valid.

## Timing
- Reset values: resp_valid=0, resp_id=0, resp_data=0, resp_err=0, rr_ptr=0, lock owner cleared; alu_* and req_ready combinational (0 with all valids low).
- Latency: accept in cycle N -> resp_valid with result in cycle N+1.
- Throughput: one op per cycle while resp_ready held high.
- Reset mid-operation: pending response discarded immediately (async), no req_ready until rst deasserts.
- Simultaneous req_valid on all: grants rotate 0,1,2,3,0… starting at rr_ptr.

## Configuration
- ALU_SCHED_LOCK_EN defined: after issue from i with req_lock[i]=1, owner=i; while owner set and req_valid[owner]=1, only owner may be granted. Owner released when an issue occurs with req_lock[owner]=0, or when req_valid[owner]=0 in a cycle with can_issue. rr_ptr updates as normal on the releasing issue.
- Undefined: req_lock port present but ignored; pure round-robin.

## Structure
- Package alu_sched_pkg: ALU function code enum (ADD..func5 = 0..5), FUNC_ILLEGAL_MIN=6, FSM state typedef (EMPTY, FULL).
- Sub-module rr_arbiter (NUM_REQ; req, ptr -> one-hot grant, grant index); reused by other shared-resource schedulers.

## Test plan
- Reset: hold rst with req_valid=4'b1111 -> req_ready=0, resp_valid=0; release -> first grant to requester 0.
- All four valid, resp_ready=1, 8 cycles -> resp_id sequence 0,1,2,3,0,1,2,3 at one per cycle, each resp_data equal to ALU model for that requester's func/operands.
- Back-pressure: resp_ready=0 for 3 cycles after first response -> resp_valid/resp_id/resp_data stable, req_ready all 0; resp_ready=1 -> next op accepted same cycle.
- Illegal: requester 2 func=7, a=5 -> resp_err=1, resp_data=0, resp_id=2; alu_func observed 0 that cycle.
- Fairness: requester 1 only valid 3 times, then 1 and 3 valid with rr_ptr=2 -> grant 3 before 1.
- ALU_SCHED_LOCK_EN: requester 0 lock=1 for 3 ops while 1–3 valid -> responses 0,0,0 then lock=0 op from 0, then 1.
